// File: rtl/uart_cmd_pkg.sv
// Shared types and defaults for the UART command receiver.
package uart_cmd_pkg;

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} rx_state_t;
    typedef enum logic {WAIT_HIGH, WAIT_LOW} asm_state_t;

    localparam int DEFAULT_BAUD_DIV = 2604;

endpackage

// File: rtl/uart_cmd_rcv_rx.sv
// 8N1 byte receiver: RX synchronizer, baud/bit counters and the RX state machine.
module uart_rx_byte
    import uart_cmd_pkg::*;
#(
    parameter int BAUD_DIV = DEFAULT_BAUD_DIV
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       RX,
    output logic [7:0] rx_byte,
    output logic       byte_vld,
    output logic       frm_err,
    output logic       start_acc
);

    localparam int CW = $clog2(BAUD_DIV + 1);
    localparam logic [CW-1:0] HALF_BIT = CW'(BAUD_DIV / 2);
    // Down-count includes the zero cycle, so reloading BAUD_DIV-1 keeps one bit = BAUD_DIV clocks.
    localparam logic [CW-1:0] FULL_BIT = CW'(BAUD_DIV - 1);

    logic            sync1_q;
    logic            rx_s_q;
    rx_state_t       state_q, state_d;
    logic [CW-1:0]   baud_q, baud_d;
    logic [3:0]      bit_q, bit_d;
    logic [7:0]      shift_q, shift_d;
    logic            byte_vld_q, byte_vld_d;
    logic            frm_err_q, frm_err_d;
    logic            start_acc_q, start_acc_d;

    always_comb begin
        state_d     = state_q;
        baud_d      = baud_q;
        bit_d       = bit_q;
        shift_d     = shift_q;
        byte_vld_d  = 1'b0;
        frm_err_d   = 1'b0;
        start_acc_d = 1'b0;
        case (state_q)
            IDLE: begin
                if (!rx_s_q) begin
                    baud_d  = HALF_BIT;
                    state_d = START;
                end
            end
            START: begin
                if (baud_q != '0) begin
                    baud_d = baud_q - 1'b1;
                end else if (rx_s_q) begin
                    state_d = IDLE;
                end else begin
                    baud_d      = FULL_BIT;
                    bit_d       = '0;
                    start_acc_d = 1'b1;
                    state_d     = DATA;
                end
            end
            DATA: begin
                if (baud_q != '0) begin
                    baud_d = baud_q - 1'b1;
                end else begin
                    shift_d = {rx_s_q, shift_q[7:1]};
                    baud_d  = FULL_BIT;
                    bit_d   = bit_q + 1'b1;
                    if (bit_q == 4'd7) begin
                        state_d = STOP;
                    end
                end
            end
            STOP: begin
                if (baud_q != '0) begin
                    baud_d = baud_q - 1'b1;
                end else begin
                    byte_vld_d = rx_s_q;
                    frm_err_d  = !rx_s_q;
                    state_d    = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1_q     <= 1'b1;
            rx_s_q      <= 1'b1;
            state_q     <= IDLE;
            baud_q      <= '0;
            bit_q       <= '0;
            shift_q     <= '0;
            byte_vld_q  <= 1'b0;
            frm_err_q   <= 1'b0;
            start_acc_q <= 1'b0;
        end else begin
            sync1_q     <= RX;
            rx_s_q      <= sync1_q;
            state_q     <= state_d;
            baud_q      <= baud_d;
            bit_q       <= bit_d;
            shift_q     <= shift_d;
            byte_vld_q  <= byte_vld_d;
            frm_err_q   <= frm_err_d;
            start_acc_q <= start_acc_d;
        end
    end

    assign rx_byte   = shift_q;
    assign byte_vld  = byte_vld_q;
    assign frm_err   = frm_err_q;
    assign start_acc = start_acc_q;

endmodule

// File: rtl/uart_cmd_rcv.sv
// Serial command front end: pairs received bytes into 16-bit commands, high byte first.
module uart_cmd_rcv
    import uart_cmd_pkg::*;
#(
    parameter int BAUD_DIV = DEFAULT_BAUD_DIV
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        RX,
    input  logic        clr_cmd_rdy,
    output logic [15:0] cmd,
    output logic        cmd_rdy,
    output logic        frm_err
);

    // Handshake: byte_vld/frm_err/start_acc are single-cycle pulses with no back-pressure;
    // cmd_rdy is sticky until clr_cmd_rdy (or a new command start), and a set beats a clear.

    logic [7:0] rx_byte;
    logic       byte_vld;
    logic       start_acc;

    asm_state_t asm_q, asm_d;
    logic [7:0] hi_q, hi_d;
    logic [15:0] cmd_q, cmd_d;
    logic       cmd_rdy_q, cmd_rdy_d;
    logic       set_rdy;

    uart_rx_byte #(
        .BAUD_DIV(BAUD_DIV)
    ) u_rx (
        .clk      (clk),
        .rst      (rst),
        .RX       (RX),
        .rx_byte  (rx_byte),
        .byte_vld (byte_vld),
        .frm_err  (frm_err),
        .start_acc(start_acc)
    );

    always_comb begin
        asm_d     = asm_q;
        hi_d      = hi_q;
        cmd_d     = cmd_q;
        cmd_rdy_d = cmd_rdy_q;
        set_rdy   = 1'b0;
        case (asm_q)
            WAIT_HIGH: begin
                if (byte_vld) begin
                    hi_d  = rx_byte;
                    asm_d = WAIT_LOW;
                end
            end
            WAIT_LOW: begin
                if (byte_vld) begin
                    cmd_d   = {hi_q, rx_byte};
                    set_rdy = 1'b1;
                    asm_d   = WAIT_HIGH;
                end
            end
            default: asm_d = WAIT_HIGH;
        endcase
        if (frm_err) begin
            asm_d = WAIT_HIGH;
        end
        // A start bit accepted while waiting for a high byte means the old command is stale.
        if (set_rdy) begin
            cmd_rdy_d = 1'b1;
        end else if (clr_cmd_rdy || (start_acc && asm_q == WAIT_HIGH)) begin
            cmd_rdy_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            asm_q     <= WAIT_HIGH;
            hi_q      <= '0;
            cmd_q     <= '0;
            cmd_rdy_q <= 1'b0;
        end else begin
            asm_q     <= asm_d;
            hi_q      <= hi_d;
            cmd_q     <= cmd_d;
            cmd_rdy_q <= cmd_rdy_d;
        end
    end

    assign cmd     = cmd_q;
    assign cmd_rdy = cmd_rdy_q;

endmodule

// File: tb/tb_uart_cmd_rcv.sv
// Directed bench for uart_cmd_rcv at BAUD_DIV=16: command assembly, clears, errors, glitches, reset.
module tb_uart_cmd_rcv;
    import uart_cmd_pkg::*;

    localparam int BAUD_DIV = 16;

    logic        clk;
    logic        rst;
    logic        RX;
    logic        clr_cmd_rdy;
    logic [15:0] cmd;
    logic        cmd_rdy;
    logic        frm_err;

    int vectors = 0;
    int miscompares = 0;

    int cyc = 0;
    int vld_cnt = 0;
    int ferr_cnt = 0;
    int last_vld_cyc = -1;
    int rise_cyc = -1;
    logic prev_rdy = 1'b0;

    uart_cmd_rcv #(
        .BAUD_DIV(BAUD_DIV)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .RX         (RX),
        .clr_cmd_rdy(clr_cmd_rdy),
        .cmd        (cmd),
        .cmd_rdy    (cmd_rdy),
        .frm_err    (frm_err)
    );

    // clock
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // event monitor, sampled on the falling edge
    always @(negedge clk) begin
        cyc++;
        if (dut.u_rx.byte_vld === 1'b1) begin
            vld_cnt++;
            last_vld_cyc = cyc;
        end
        if (frm_err === 1'b1) ferr_cnt++;
        if (cmd_rdy === 1'b1 && prev_rdy !== 1'b1) rise_cyc = cyc;
        prev_rdy = cmd_rdy;
    end

    // driver tasks: always entered and left on a falling edge
    task automatic send_frame(input logic [7:0] d, input logic stop_ok);
        RX = 1'b0;
        repeat (BAUD_DIV) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            RX = d[i];
            repeat (BAUD_DIV) @(negedge clk);
        end
        RX = stop_ok;
        repeat (BAUD_DIV) @(negedge clk);
        RX = 1'b1;
    endtask

    task automatic idle_bits(input int n);
        RX = 1'b1;
        repeat (n * BAUD_DIV) @(negedge clk);
    endtask

    task automatic test_reset;
        rst = 1'b1;
        RX = 1'b1;
        clr_cmd_rdy = 1'b0;
        repeat (3) @(negedge clk);
        vectors++;
        if (cmd !== 16'h0000) begin
            miscompares++;
            $display("FAIL reset_cmd: got %h expected 0000", cmd);
        end
        vectors++;
        if (cmd_rdy !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_cmd_rdy: got %b expected 0", cmd_rdy);
        end
        vectors++;
        if (frm_err !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_frm_err: got %b expected 0", frm_err);
        end
        vectors++;
        if (dut.u_rx.state_q !== IDLE) begin
            miscompares++;
            $display("FAIL reset_rx_state: got %0d expected %0d", dut.u_rx.state_q, IDLE);
        end
        vectors++;
        if (dut.asm_q !== WAIT_HIGH) begin
            miscompares++;
            $display("FAIL reset_asm_state: got %0d expected %0d", dut.asm_q, WAIT_HIGH);
        end
        rst = 1'b0;
        idle_bits(1);
    endtask

    task automatic test_basic;
        int e0;
        e0 = ferr_cnt;
        send_frame(8'hA5, 1'b1);
        idle_bits(2);
        send_frame(8'h3C, 1'b1);
        vectors++;
        if (cmd !== 16'hA53C) begin
            miscompares++;
            $display("FAIL basic_cmd: got %h expected a53c", cmd);
        end
        vectors++;
        if (cmd_rdy !== 1'b1) begin
            miscompares++;
            $display("FAIL basic_cmd_rdy: got %b expected 1", cmd_rdy);
        end
        vectors++;
        if (rise_cyc != last_vld_cyc + 1) begin
            miscompares++;
            $display("FAIL basic_latency: cmd_rdy rose %0d cycles after byte_vld, expected 1",
                     rise_cyc - last_vld_cyc);
        end
        vectors++;
        if (ferr_cnt != e0) begin
            miscompares++;
            $display("FAIL basic_no_frm_err: got %0d pulses expected 0", ferr_cnt - e0);
        end
        idle_bits(1);
    endtask

    task automatic test_set_wins;
        bit seen;
        seen = 1'b0;
        send_frame(8'h12, 1'b1);
        idle_bits(1);
        fork
            send_frame(8'h34, 1'b1);
            begin
                for (int i = 0; i < 400 && !seen; i++) begin
                    if (dut.u_rx.byte_vld === 1'b1) begin
                        seen = 1'b1;
                        clr_cmd_rdy = 1'b1;
                    end
                    @(negedge clk);
                end
                clr_cmd_rdy = 1'b0;
            end
        join
        vectors++;
        if (!seen) begin
            miscompares++;
            $display("FAIL set_wins_timeout: byte_vld not seen within 400 cycles");
        end
        vectors++;
        if (cmd !== 16'h1234) begin
            miscompares++;
            $display("FAIL set_wins_cmd: got %h expected 1234", cmd);
        end
        vectors++;
        if (cmd_rdy !== 1'b1) begin
            miscompares++;
            $display("FAIL set_wins_cmd_rdy: got %b expected 1", cmd_rdy);
        end
        clr_cmd_rdy = 1'b1;
        @(negedge clk);
        clr_cmd_rdy = 1'b0;
        vectors++;
        if (cmd_rdy !== 1'b0) begin
            miscompares++;
            $display("FAIL clr_cmd_rdy: got %b expected 0", cmd_rdy);
        end
        vectors++;
        if (cmd !== 16'h1234) begin
            miscompares++;
            $display("FAIL clr_keeps_cmd: got %h expected 1234", cmd);
        end
        idle_bits(1);
    endtask

    task automatic test_frame_err;
        int e0;
        e0 = ferr_cnt;
        send_frame(8'h77, 1'b1);
        idle_bits(1);
        send_frame(8'hFF, 1'b0);
        idle_bits(2);
        send_frame(8'h01, 1'b1);
        idle_bits(1);
        send_frame(8'h02, 1'b1);
        vectors++;
        if (ferr_cnt - e0 != 1) begin
            miscompares++;
            $display("FAIL frm_err_count: got %0d cycles expected 1", ferr_cnt - e0);
        end
        vectors++;
        if (cmd !== 16'h0102) begin
            miscompares++;
            $display("FAIL frm_err_cmd: got %h expected 0102", cmd);
        end
        vectors++;
        if (cmd_rdy !== 1'b1) begin
            miscompares++;
            $display("FAIL frm_err_cmd_rdy: got %b expected 1", cmd_rdy);
        end
        idle_bits(1);
    endtask

    task automatic test_glitch;
        int v0, e0;
        v0 = vld_cnt;
        e0 = ferr_cnt;
        RX = 1'b0;
        repeat (4) @(negedge clk);
        RX = 1'b1;
        repeat (40) @(negedge clk);
        vectors++;
        if (vld_cnt != v0) begin
            miscompares++;
            $display("FAIL glitch_byte_vld: got %0d pulses expected 0", vld_cnt - v0);
        end
        vectors++;
        if (ferr_cnt != e0) begin
            miscompares++;
            $display("FAIL glitch_frm_err: got %0d pulses expected 0", ferr_cnt - e0);
        end
        vectors++;
        if (dut.u_rx.state_q !== IDLE) begin
            miscompares++;
            $display("FAIL glitch_state: got %0d expected %0d", dut.u_rx.state_q, IDLE);
        end
        vectors++;
        if (cmd_rdy !== 1'b1 || cmd !== 16'h0102) begin
            miscompares++;
            $display("FAIL glitch_cmd: got %b/%h expected 1/0102", cmd_rdy, cmd);
        end
    endtask

    task automatic test_reset_mid;
        logic [7:0] d;
        d = 8'hBE;
        RX = 1'b0;
        repeat (BAUD_DIV) @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            RX = d[i];
            repeat (BAUD_DIV) @(negedge clk);
        end
        rst = 1'b1;
        RX = 1'b1;
        repeat (2) @(negedge clk);
        vectors++;
        if (cmd !== 16'h0000 || cmd_rdy !== 1'b0 || dut.u_rx.state_q !== IDLE) begin
            miscompares++;
            $display("FAIL reset_mid_state: got cmd %h rdy %b state %0d expected 0000 0 %0d",
                     cmd, cmd_rdy, dut.u_rx.state_q, IDLE);
        end
        rst = 1'b0;
        idle_bits(1);
        send_frame(8'hC0, 1'b1);
        idle_bits(1);
        send_frame(8'hDE, 1'b1);
        vectors++;
        if (cmd !== 16'hC0DE || cmd_rdy !== 1'b1) begin
            miscompares++;
            $display("FAIL reset_mid_cmd: got %h/%b expected c0de/1", cmd, cmd_rdy);
        end
        idle_bits(1);
    endtask

    task automatic test_stale_drop;
        logic early_rdy;
        send_frame(8'h03, 1'b1);
        idle_bits(1);
        send_frame(8'h03, 1'b1);
        idle_bits(1);
        vectors++;
        if (cmd !== 16'h0303 || cmd_rdy !== 1'b1) begin
            miscompares++;
            $display("FAIL stale_first_cmd: got %h/%b expected 0303/1", cmd, cmd_rdy);
        end
        fork
            send_frame(8'h01, 1'b1);
            begin
                repeat (6) @(negedge clk);
                early_rdy = cmd_rdy;
            end
        join
        vectors++;
        if (early_rdy !== 1'b1) begin
            miscompares++;
            $display("FAIL stale_before_accept: got %b expected 1", early_rdy);
        end
        vectors++;
        if (cmd_rdy !== 1'b0 || cmd !== 16'h0303) begin
            miscompares++;
            $display("FAIL stale_dropped: got %b/%h expected 0/0303", cmd_rdy, cmd);
        end
        idle_bits(1);
        send_frame(8'h02, 1'b1);
        vectors++;
        if (cmd !== 16'h0102 || cmd_rdy !== 1'b1) begin
            miscompares++;
            $display("FAIL stale_new_cmd: got %h/%b expected 0102/1", cmd, cmd_rdy);
        end
        idle_bits(1);
    endtask

    task automatic test_back_to_back;
        send_frame(8'h5A, 1'b1);
        send_frame(8'hA5, 1'b1);
        vectors++;
        if (cmd !== 16'h5AA5 || cmd_rdy !== 1'b1) begin
            miscompares++;
            $display("FAIL back_to_back: got %h/%b expected 5aa5/1", cmd, cmd_rdy);
        end
        idle_bits(1);
    endtask

    initial begin
        rst = 1'b1;
        RX = 1'b1;
        clr_cmd_rdy = 1'b0;
        @(negedge clk);
        test_reset();
        test_basic();
        test_set_wins();
        test_frame_err();
        test_glitch();
        test_reset_mid();
        test_stale_drop();
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
